// File: rtl/cgra_seq.sv
// cgra_seq: launch sequencer for a CGRA accelerator.
// It fetches cfg_len_i configuration words from data memory, starting at
// base_addr_i, and writes each one into the CGRA configuration slots. It
// then clears the CGRA for one cycle and enables it until cgra_done_i
// arrives or the optional run timeout expires.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start_i         - one-cycle launch pulse (ignored unless idle)
//   base_addr_i     - first configuration word address
//   cfg_len_i       - number of configuration words (0 = skip loading)
//   run_cycles_i    - run timeout in cycles (0 = wait for cgra_done_i)
//   busy_o          - sequence in progress (CPU stall)
//   done_o          - one-cycle completion pulse
//   err_o           - last run ended by timeout, held until next start
//   mem_req_o/mem_addr_o/mem_gnt_i/mem_rvalid_i/mem_rdata_i
//                   - single-outstanding read port to data memory
//   cfg_we_o/cfg_idx_o/cfg_data_o
//                   - configuration slot write port
//   cgra_rst_o      - one-cycle CGRA state clear
//   cgra_en_o       - CGRA execute enable
//   cgra_done_i     - CGRA execution finished
module cgra_seq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [IDX_W-1:0]  cfg_len_i,
  input  logic [15:0]       run_cycles_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cfg_we_o,
  output logic [IDX_W-1:0]  cfg_idx_o,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cgra_rst_o,
  output logic              cgra_en_o,
  input  logic              cgra_done_i
);

  typedef enum logic [2:0] {
    IDLE,
    CFG_REQ,
    CFG_WAIT,
    CLR,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  len_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [15:0]       run_q;
  logic [15:0]       run_cnt;

  logic [IDX_W-1:0]  cnt_nxt;
  logic              last_word;
  logic              timeout_hit;

  assign cnt_nxt     = cnt_q + IDX_W'(1);
  assign last_word   = (cnt_q == len_q - IDX_W'(1));
  assign timeout_hit = (run_q != '0) && (run_cnt == run_q - 16'd1);

  // Outputs are registered, so each one is set on the transition into the
  // state where it must be visible and cleared on the transition out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      run_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      cfg_we_o   <= 1'b0;
      cfg_idx_o  <= '0;
      cfg_data_o <= '0;
      cgra_rst_o <= 1'b0;
      cgra_en_o  <= 1'b0;
    end else begin
      cfg_we_o   <= 1'b0;
      cgra_rst_o <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            base_q <= base_addr_i;
            len_q  <= cfg_len_i;
            run_q  <= run_cycles_i;
            cnt_q  <= '0;
            err_o  <= 1'b0;
            busy_o <= 1'b1;
            if (cfg_len_i == '0) begin
              state      <= CLR;
              cgra_rst_o <= 1'b1;
            end else begin
              state      <= CFG_REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= base_addr_i;
            end
          end
        end
        CFG_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= CFG_WAIT;
          end
        end
        CFG_WAIT: begin
          if (mem_rvalid_i) begin
            cfg_we_o   <= 1'b1;
            cfg_idx_o  <= cnt_q;
            cfg_data_o <= mem_rdata_i;
            cnt_q      <= cnt_nxt;
            if (last_word) begin
              state      <= CLR;
              cgra_rst_o <= 1'b1;
            end else begin
              state      <= CFG_REQ;
              mem_req_o  <= 1'b1;
              // address arithmetic wraps naturally at ADDR_W bits
              mem_addr_o <= base_q + ADDR_W'(cnt_nxt);
            end
          end
        end
        CLR: begin
          run_cnt   <= '0;
          cgra_en_o <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (run_cnt != '1) begin
            run_cnt <= run_cnt + 16'd1;
          end
          // completion wins over a coincident timeout
          if (cgra_done_i || timeout_hit) begin
            state     <= DONE;
            cgra_en_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= ~cgra_done_i;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_seq.sv
// Directed testbench for cgra_seq: a table of full launch sequences with
// hand-computed latency/enable/error expectations, driven through a
// zero-wait (optionally delayed-grant) memory responder, followed by
// hand-written reset corner cases.
module tb_cgra_seq;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 6;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [IDX_W-1:0]  cfg_len_i;
  logic [15:0]       run_cycles_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              cfg_we_o;
  logic [IDX_W-1:0]  cfg_idx_o;
  logic [DATA_W-1:0] cfg_data_o;
  logic              cgra_rst_o;
  logic              cgra_en_o;
  logic              cgra_done_i;

  cgra_seq #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .cfg_len_i   (cfg_len_i),
    .run_cycles_i(run_cycles_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .cfg_we_o    (cfg_we_o),
    .cfg_idx_o   (cfg_idx_o),
    .cfg_data_o  (cfg_data_o),
    .cgra_rst_o  (cgra_rst_o),
    .cgra_en_o   (cgra_en_o),
    .cgra_done_i (cgra_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents: word at address a holds 0x90 + a (so 0x010 -> 0xA0).
  typedef struct {
    logic [ADDR_W-1:0] base;
    int unsigned       len;
    int unsigned       tmo;
    int unsigned       done_at;     // RUN cycle in which cgra_done_i is raised, 0 = never
    int unsigned       gnt_delay;   // request cycles withheld before each grant
    int unsigned       extra_start; // cycle of a spurious start_i, 0 = none
    int unsigned       exp_en;
    logic              exp_err;
    int unsigned       exp_lat;     // cycles from start_i to done_o
  } vec_t;

  vec_t vecs[6];

  task automatic run_seq(input vec_t v, input int unsigned id);
    int unsigned cyc, nw, ngrant, nrst, en_count, delay_cnt, lat;
    logic pending, req_open, err_at_done, seen_done;
    logic [DATA_W-1:0] pend_data;
    logic [ADDR_W-1:0] ea;
    cyc = 0; nw = 0; ngrant = 0; nrst = 0; en_count = 0; delay_cnt = 0; lat = 0;
    pending = 1'b0; req_open = 1'b0; err_at_done = 1'b0; seen_done = 1'b0;
    pend_data = '0;
    @(negedge clk);
    base_addr_i  = v.base;
    cfg_len_i    = IDX_W'(v.len);
    run_cycles_i = 16'(v.tmo);
    start_i      = 1'b1;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_i      = 1'b0;
        base_addr_i  = v.base ^ 10'h155;
        cfg_len_i    = 6'd7;
        run_cycles_i = 16'd1;
      end
      if (v.extra_start != 0 && cyc == v.extra_start) start_i = 1'b1;
      if (v.extra_start != 0 && cyc == v.extra_start + 1) start_i = 1'b0;
      if (cfg_we_o) begin
        ea = v.base + ADDR_W'(nw);
        chk($sformatf("v%0d cfg_idx", id), 32'(cfg_idx_o), nw);
        chk($sformatf("v%0d cfg_data", id), cfg_data_o, 32'h90 + 32'(ea));
        nw++;
      end
      if (cgra_rst_o) begin
        nrst++;
        chk($sformatf("v%0d en_during_clr", id), 32'(cgra_en_o), 0);
      end
      if (cgra_en_o) en_count++;
      if (done_o) begin
        seen_done   = 1'b1;
        lat         = cyc;
        err_at_done = err_o;
        chk($sformatf("v%0d busy_at_done", id), 32'(busy_o), 0);
      end else begin
        chk($sformatf("v%0d busy", id), 32'(busy_o), 1);
      end
      mem_rvalid_i = pending;
      mem_rdata_i  = pending ? pend_data : 32'hDEAD_BEEF;
      pending      = 1'b0;
      mem_gnt_i    = 1'b0;
      if (req_open) chk($sformatf("v%0d req_held", id), 32'(mem_req_o), 1);
      if (mem_req_o) begin
        ea = v.base + ADDR_W'(ngrant);
        chk($sformatf("v%0d mem_addr", id), 32'(mem_addr_o), 32'(ea));
        if (delay_cnt == v.gnt_delay) begin
          mem_gnt_i = 1'b1;
          pending   = 1'b1;
          pend_data = 32'h90 + 32'(mem_addr_o);
          ngrant++;
          delay_cnt = 0;
          req_open  = 1'b0;
        end else begin
          delay_cnt++;
          req_open = 1'b1;
        end
      end
      cgra_done_i = cgra_en_o && (v.done_at != 0) && (en_count == v.done_at);
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; cgra_done_i = 1'b0; start_i = 1'b0;
    chk($sformatf("v%0d done_seen", id), 32'(seen_done), 1);
    chk($sformatf("v%0d latency", id), lat, v.exp_lat);
    chk($sformatf("v%0d err", id), 32'(err_at_done), 32'(v.exp_err));
    chk($sformatf("v%0d en_cycles", id), en_count, v.exp_en);
    chk($sformatf("v%0d writes", id), nw, v.len);
    chk($sformatf("v%0d grants", id), ngrant, v.len);
    chk($sformatf("v%0d clr_pulses", id), nrst, 1);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", id), 32'(done_o), 0);
    chk($sformatf("v%0d idle_busy", id), 32'(busy_o), 0);
    chk($sformatf("v%0d err_held", id), 32'(err_o), 32'(v.exp_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy_o), 0);
    chk({tag, " done"}, 32'(done_o), 0);
    chk({tag, " err"}, 32'(err_o), 0);
    chk({tag, " mem_req"}, 32'(mem_req_o), 0);
    chk({tag, " cfg_we"}, 32'(cfg_we_o), 0);
    chk({tag, " cgra_rst"}, 32'(cgra_rst_o), 0);
    chk({tag, " cgra_en"}, 32'(cgra_en_o), 0);
  endtask

  initial begin
    vec_t fresh;
    //          base    len tmo done gd xs  en  err   lat
    vecs[0] = '{10'h010, 3, 0,  5,   0, 0,  5, 1'b0, 13};
    vecs[1] = '{10'h020, 0, 4,  0,   0, 0,  4, 1'b1, 6};
    vecs[2] = '{10'h3FF, 2, 3,  0,   0, 0,  3, 1'b1, 9};
    vecs[3] = '{10'h100, 1, 6,  6,   0, 0,  6, 1'b0, 10};
    vecs[4] = '{10'h3FE, 4, 2,  1,   0, 0,  1, 1'b0, 11};
    vecs[5] = '{10'h040, 2, 2,  0,   3, 2,  2, 1'b1, 14};
    fresh   = '{10'h200, 2, 3,  0,   0, 0,  3, 1'b1, 9};

    rst = 1'b1; start_i = 1'b0; base_addr_i = '0; cfg_len_i = '0; run_cycles_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; cgra_done_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");
    chk("reset mem_addr", 32'(mem_addr_o), 0);

    for (int i = 0; i < 6; i++) run_seq(vecs[i], i);

    // err stays set while idle, and reset clears it
    repeat (3) @(negedge clk);
    chk("err_hold_idle", 32'(err_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clears_err", 32'(err_o), 0);

    // reset while waiting for read data, then a late rvalid
    base_addr_i = 10'h050; cfg_len_i = 6'd2; run_cycles_i = 16'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("rstmid req", 32'(mem_req_o), 1);
    chk("rstmid addr", 32'(mem_addr_o), 32'h050);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("rstmid wait_busy", 32'(busy_o), 1);
    chk("rstmid wait_noreq", 32'(mem_req_o), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rstmid");
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0055;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    chk("late_rvalid we", 32'(cfg_we_o), 0);
    chk("late_rvalid busy", 32'(busy_o), 0);
    chk("late_rvalid req", 32'(mem_req_o), 0);
    @(negedge clk);
    chk("late_rvalid we2", 32'(cfg_we_o), 0);
    chk("late_rvalid done", 32'(done_o), 0);

    run_seq(fresh, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cgra_seq.md
CGRA_SEQ -- requirements
Module: cgra_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, which is the data-memory word-address width and matches the CPU debug address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, which is the configuration and data word width.
REQ-003 The block SHALL have parameter IDX_W, default 6, which is the configuration slot index width (up to 63 words).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start_i, input, 1 bit: one-cycle launch pulse from the CPU custom-instruction decode.
REQ-007 The block SHALL have port base_addr_i, input, ADDR_W bits: first configuration word address.
REQ-008 The block SHALL have port cfg_len_i, input, IDX_W bits: number of configuration words to load.
REQ-009 The block SHALL have port run_cycles_i, input, 16 bits: run timeout in cycles, where 0 means no timeout.
REQ-010 The block SHALL have port busy_o, output, 1 bit: sequence in progress, used by the CPU as its stall.
REQ-011 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err_o, output, 1 bit: the last run ended by timeout.
REQ-013 The block SHALL have port mem_req_o, output, 1 bit: memory read request.
REQ-014 The block SHALL have port mem_addr_o, output, ADDR_W bits: memory read address.
REQ-015 The block SHALL have port mem_gnt_i, input, 1 bit: request accepted.
REQ-016 The block SHALL have port mem_rvalid_i, input, 1 bit: read data valid.
REQ-017 The block SHALL have port mem_rdata_i, input, DATA_W bits: read data.
REQ-018 The block SHALL have port cfg_we_o, output, 1 bit: CGRA configuration write strobe.
REQ-019 The block SHALL have port cfg_idx_o, output, IDX_W bits: configuration slot index.
REQ-020 The block SHALL have port cfg_data_o, output, DATA_W bits: configuration word.
REQ-021 The block SHALL have port cgra_rst_o, output, 1 bit: one-cycle CGRA state clear.
REQ-022 The block SHALL have port cgra_en_o, output, 1 bit: CGRA execute enable.
REQ-023 The block SHALL have port cgra_done_i, input, 1 bit: CGRA signals that execution has finished.

Function
REQ-024 The FSM SHALL have the states IDLE, CFG_REQ, CFG_WAIT, CLR, RUN and DONE, and every output SHALL be registered.
REQ-025 In IDLE, a start_i pulse SHALL latch base_addr_i, cfg_len_i and run_cycles_i, clear err_o and the word counter, and move to CFG_REQ, or to CLR if cfg_len_i equals 0.
REQ-026 In CFG_REQ, the block SHALL hold mem_req_o at 1 with mem_addr_o equal to base plus counter (modulo 2^ADDR_W, so addresses wrap from 1023 to 0) until mem_gnt_i is 1, then move to CFG_WAIT with mem_req_o at 0.
REQ-027 In CFG_WAIT, a mem_rvalid_i of 1 SHALL cause cfg_we_o to be 1 on the next cycle, for exactly one cycle, with cfg_idx_o equal to the counter and cfg_data_o equal to mem_rdata_i.
REQ-028 In CFG_WAIT, on mem_rvalid_i the counter SHALL increment, and the FSM SHALL go to CLR if the word just received was the last (counter equal to len-1) and to CFG_REQ otherwise.
REQ-029 The block SHALL have at most one outstanding read, and mem_rvalid_i outside CFG_WAIT SHALL be ignored.
REQ-030 CLR SHALL assert cgra_rst_o for exactly one cycle, clear the run counter, and move to RUN.
REQ-031 In RUN, cgra_en_o SHALL be 1 and the run counter SHALL increment every cycle.
REQ-032 In RUN, cgra_done_i equal to 1 SHALL move the FSM to DONE with err_o equal to 0.
REQ-033 In RUN with a nonzero timeout and cgra_done_i equal to 0, the FSM SHALL move to DONE with err_o set to 1 in the cycle in which the run counter equals run_cycles-1, giving exactly run_cycles enable cycles.
REQ-034 If cgra_done_i and the timeout occur in the same cycle, cgra_done_i SHALL take priority and err_o SHALL be 0.
REQ-035 The run counter SHALL saturate and never wrap, and a timeout of 0 SHALL mean RUN lasts until cgra_done_i.
REQ-036 DONE SHALL assert done_o for one cycle and then go to IDLE, and err_o SHALL hold its value until the next accepted start_i.
REQ-037 busy_o SHALL be 1 in CFG_REQ, CFG_WAIT, CLR and RUN, and 0 in IDLE and DONE.
REQ-038 A start_i received while not in IDLE SHALL be ignored and SHALL have no side effects.
REQ-039 With zero-wait memory (grant in the same cycle, rvalid one cycle later), each configuration word SHALL take 2 cycles.
REQ-040 Consequently, with zero-wait memory and cgra_done_i never asserted, done_o SHALL occur 1 + 2N + 1 + run_cycles cycles after start_i, and is never earlier.

Reset
REQ-041 A synchronous rst SHALL put the FSM in IDLE, return both counters and all outputs to 0, and discard any in-flight request or read.
REQ-042 A rst asserted mid-sequence SHALL produce no done_o and no further cfg_we_o, and SHALL clear err_o.

Verification
REQ-043 The bench SHALL cover: base=0x010, len=3, timeout=0, zero-wait memory returning 0xA0,0xA1,0xA2, cgra_done_i asserted on the 5th RUN cycle -> cfg writes (0,0xA0),(1,0xA1),(2,0xA2), one cgra_rst_o pulse, 5 cgra_en_o cycles, done_o with err_o=0.
REQ-044 The bench SHALL cover: len=0, timeout=4, cgra_done_i=0 -> no mem_req_o, 4 cgra_en_o cycles, done_o with err_o=1.
REQ-045 The bench SHALL cover: base=0x3FF, len=2 -> mem_addr_o equal to 0x3FF and then 0x000.
REQ-046 The bench SHALL cover: mem_gnt_i delayed by 3 cycles -> mem_req_o and mem_addr_o stable throughout the delay, and a second start_i sent during the delay ignored.
REQ-047 The bench SHALL cover: timeout=6 with cgra_done_i arriving exactly in RUN cycle 6 -> err_o=0.
REQ-048 The bench SHALL cover: rst asserted in CFG_WAIT with a late rvalid -> IDLE, outputs 0, no cfg_we_o, and a fresh start_i behaves normally.
